rf_wb_scheduler: RTL

- Shares the single register-file write port between two writeback requesters: ALU result (A) and memory load (M).
- Each requester has a valid/ready handshake and a one-entry holding slot.
- Drives the write-port controls: 4-bit destination address and Ld enable into the register-file decoder, plus write data.
- Exports a pending-write scoreboard so issue logic can interlock on registers with outstanding writes.

---
 rtl/rf_wb_pkg.sv | 19 +
 rtl/rf_wb_slot.sv | 52 +++++
 rtl/rf_wb_scheduler.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg: shared constants and types for the register-file writeback scheduler.
//   DATA_W   - write data width
//   ADDR_W   - register address width
//   NUM_REGS - number of architectural registers
//   PC_IDX   - register index that holds the program counter
//   req_id_t - identifies a writeback requester (ALU or memory load)
package rf_wb_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 16;
  localparam int PC_IDX   = 15;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_M = 1'b1
  } req_id_t;

endpackage

// File: rtl/rf_wb_slot.sv
// rf_wb_slot: one-entry holding register for a writeback request.
//   clk_i   - clock, rising edge
//   rst_ni  - asynchronous active-low reset, empties the slot
//   load_i  - capture addr_i/data_i and mark the slot valid
//   clear_i - free the slot (ignored when load_i is also high)
//   addr_i  - destination register to capture
//   data_i  - write data to capture
//   valid_o - slot holds an entry
//   addr_o  - held destination register
//   data_o  - held write data
module rf_wb_slot
  import rf_wb_pkg::*;
#(
  parameter int DW = rf_wb_pkg::DATA_W,
  parameter int AW = rf_wb_pkg::ADDR_W
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic          clear_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] data_i,
  output logic          valid_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] data_o
);

  logic          valid_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;

  // Load has priority over clear so that a slot drained and refilled on the
  // same edge ends up holding the new entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      addr_q  <= addr_i;
      data_q  <= data_i;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;

endmodule

// File: rtl/rf_wb_scheduler.sv
// rf_wb_scheduler: shares the single register-file write port between the
// ALU writeback (A) and the memory-load writeback (M).
//   clk, rst_n                  - clock (rising edge), async active-low reset
//   en                          - global enable, 0 stalls all grants
//   a_valid/a_ready/a_addr/a_data - ALU writeback handshake and payload
//   m_valid/m_ready/m_addr/m_data - load writeback handshake and payload
//   wr_ld, wr_addr, wr_data     - registered register-file write port
//   pc_wr                       - pulses with wr_ld when writing the PC
//   pending                     - bit i set while a write to Ri is outstanding
module rf_wb_scheduler
  import rf_wb_pkg::*;
#(
  parameter int DATA_W = rf_wb_pkg::DATA_W,
  parameter int ADDR_W = rf_wb_pkg::ADDR_W,
  parameter int PC_IDX = rf_wb_pkg::PC_IDX
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [ADDR_W-1:0]    a_addr,
  input  logic [DATA_W-1:0]    a_data,
  input  logic                 m_valid,
  output logic                 m_ready,
  input  logic [ADDR_W-1:0]    m_addr,
  input  logic [DATA_W-1:0]    m_data,
  output logic                 wr_ld,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [DATA_W-1:0]    wr_data,
  output logic                 pc_wr,
  output logic [2**ADDR_W-1:0] pending
);

  logic              sa_valid, sm_valid;
  logic [ADDR_W-1:0] sa_addr, sm_addr;
  logic [DATA_W-1:0] sa_data, sm_data;
  logic              grant_a, grant_m;
  logic              load_a, load_m;
  logic              sa_valid_d, sm_valid_d;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_data;

  req_id_t           rr_last_q;
  req_id_t           older_q, older_d;
  logic              older_vld_q, older_vld_d;
  logic              wr_ld_q, pc_wr_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  rf_wb_slot #(.DW(DATA_W), .AW(ADDR_W)) u_slot_a (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .load_i  (load_a),
    .clear_i (grant_a),
    .addr_i  (a_addr),
    .data_i  (a_data),
    .valid_o (sa_valid),
    .addr_o  (sa_addr),
    .data_o  (sa_data)
  );

  rf_wb_slot #(.DW(DATA_W), .AW(ADDR_W)) u_slot_m (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .load_i  (load_m),
    .clear_i (grant_m),
    .addr_i  (m_addr),
    .data_i  (m_data),
    .valid_o (sm_valid),
    .addr_o  (sm_addr),
    .data_o  (sm_data)
  );

  // Grant depends only on slot state so the write port never sees a
  // combinational path from the requesters. Same-address conflicts keep
  // program order via the age flag; otherwise the port alternates.
  always_comb begin
    grant_a = 1'b0;
    grant_m = 1'b0;
    if (en) begin
      if (sa_valid && !sm_valid) begin
        grant_a = 1'b1;
      end else if (sm_valid && !sa_valid) begin
        grant_m = 1'b1;
      end else if (sa_valid && sm_valid) begin
        if ((sa_addr == sm_addr) && older_vld_q) begin
          grant_a = (older_q == REQ_A);
          grant_m = (older_q == REQ_M);
        end else begin
          grant_a = (rr_last_q == REQ_M);
          grant_m = (rr_last_q == REQ_A);
        end
      end
    end
  end

  assign a_ready = !sa_valid || grant_a;
  assign m_ready = !sm_valid || grant_m;
  assign load_a  = a_valid && a_ready;
  assign load_m  = m_valid && m_ready;

  assign sa_valid_d = load_a || (sa_valid && !grant_a);
  assign sm_valid_d = load_m || (sm_valid && !grant_m);

  // The entry that stayed put while the other slot was (re)loaded is the
  // older one; a simultaneous load makes M older. Age only has meaning
  // while both slots are occupied.
  always_comb begin
    older_vld_d = 1'b0;
    older_d     = REQ_M;
    if (sa_valid_d && sm_valid_d) begin
      older_vld_d = 1'b1;
      if (load_a && load_m) begin
        older_d = REQ_M;
      end else if (load_a) begin
        older_d = REQ_M;
      end else if (load_m) begin
        older_d = REQ_A;
      end else begin
        older_vld_d = older_vld_q;
        older_d     = older_q;
      end
    end
  end

  assign gnt_addr = grant_a ? sa_addr : sm_addr;
  assign gnt_data = grant_a ? sa_data : sm_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q   <= REQ_M;
      older_q     <= REQ_M;
      older_vld_q <= 1'b0;
      wr_ld_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      pc_wr_q     <= 1'b0;
    end else begin
      older_q     <= older_d;
      older_vld_q <= older_vld_d;
      if (grant_a || grant_m) begin
        rr_last_q <= grant_a ? REQ_A : REQ_M;
        wr_ld_q   <= 1'b1;
        wr_addr_q <= gnt_addr;
        wr_data_q <= gnt_data;
        pc_wr_q   <= (gnt_addr == ADDR_W'(PC_IDX));
      end else begin
        wr_ld_q <= 1'b0;
        pc_wr_q <= 1'b0;
      end
    end
  end

  assign wr_ld   = wr_ld_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign pc_wr   = pc_wr_q;

  // Outstanding writes: anything parked in a slot plus the write on the port.
  always_comb begin
    pending = '0;
    if (sa_valid) pending[sa_addr] = 1'b1;
    if (sm_valid) pending[sm_addr] = 1'b1;
    if (wr_ld_q)  pending[wr_addr_q] = 1'b1;
  end

endmodule
